// File: rtl/alu_if.sv
// ALU stimulus/response bundle.
// master: drives op_a, op_b, cin, mode, ce, cmd, inp_valid; receives the result bundle.
// slave : the ALU; receives the operand/command bundle, drives res, cout, oflow, G, E, L, err.
interface alu_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CMD_WIDTH = 4
);
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 cin;
    logic                 mode;
    logic                 ce;
    logic [CMD_WIDTH-1:0] cmd;
    logic [1:0]           inp_valid;
    logic [WIDTH:0]       res;
    logic                 cout;
    logic                 oflow;
    logic                 G;
    logic                 E;
    logic                 L;
    logic                 err;

    modport master (
        output op_a, op_b, cin, mode, ce, cmd, inp_valid,
        input  res, cout, oflow, G, E, L, err
    );

    modport slave (
        input  op_a, op_b, cin, mode, ce, cmd, inp_valid,
        output res, cout, oflow, G, E, L, err
    );
endinterface

// File: rtl/alu_core.sv
// ALU datapath responding on alu_if. Operands may arrive in separate cycles;
// a missing operand is waited for up to TIMEOUT clock-enabled cycles.
// Ports: clk, rst (async active-low), bus (alu_if.slave: operand/command in,
// registered res/cout/oflow/G/E/L/err out).
module alu_core #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

    // Arithmetic opcodes (mode = 1)
    localparam logic [CMD_WIDTH-1:0] A_ADD     = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] A_SUB     = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] A_ADD_CIN = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] A_SUB_CIN = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] A_INC_A   = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] A_DEC_A   = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] A_INC_B   = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] A_DEC_B   = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] A_CMP     = CMD_WIDTH'(8);
    // Logical opcodes (mode = 0)
    localparam logic [CMD_WIDTH-1:0] L_AND     = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] L_NAND    = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] L_OR      = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] L_NOR     = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] L_XOR     = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] L_XNOR    = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] L_NOT_A   = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] L_NOT_B   = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] L_SHR1_A  = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] L_SHL1_A  = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] L_SHR1_B  = CMD_WIDTH'(10);
    localparam logic [CMD_WIDTH-1:0] L_SHL1_B  = CMD_WIDTH'(11);
    localparam logic [CMD_WIDTH-1:0] L_ROL     = CMD_WIDTH'(12);
    localparam logic [CMD_WIDTH-1:0] L_ROR     = CMD_WIDTH'(13);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 a_vld_q, b_vld_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic                 mode_q, cin_q;

    logic                 in_wait_c;
    logic [WIDTH-1:0]     eff_a_c, eff_b_c;
    logic [CMD_WIDTH-1:0] eff_cmd_c;
    logic                 eff_mode_c, eff_cin_c;
    logic                 have_a_c, have_b_c;
    logic                 need_a_c, need_b_c, illegal_c, done_c;
    logic [SHAMT_W-1:0]   rot_amt_c;
    logic                 rot_bad_c;
    logic [WIDTH-1:0]     rol_c, ror_c;
    logic [WIDTH:0]       xa_c, xb_c, xc_c;
    logic [WIDTH:0]       r_res_c;
    logic                 r_cout_c, r_oflow_c, r_g_c, r_e_c, r_l_c, r_err_c;

    // Operands seen this cycle: fresh inputs win over held ones; command is frozen while waiting.
    always_comb begin
        in_wait_c  = (state_q == ST_WAIT);
        eff_a_c    = bus.inp_valid[0] ? bus.op_a : a_q;
        eff_b_c    = bus.inp_valid[1] ? bus.op_b : b_q;
        eff_cmd_c  = in_wait_c ? cmd_q  : bus.cmd;
        eff_mode_c = in_wait_c ? mode_q : bus.mode;
        eff_cin_c  = in_wait_c ? cin_q  : bus.cin;
        have_a_c   = bus.inp_valid[0] | (in_wait_c & a_vld_q);
        have_b_c   = bus.inp_valid[1] | (in_wait_c & b_vld_q);
    end

    // Operand requirement and legality of the effective command.
    always_comb begin
        need_a_c  = 1'b1;
        need_b_c  = 1'b1;
        illegal_c = 1'b0;
        if (eff_mode_c) begin
            case (eff_cmd_c)
                A_INC_A, A_DEC_A: need_b_c = 1'b0;
                A_INC_B, A_DEC_B: need_a_c = 1'b0;
                A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: ;
                default: illegal_c = 1'b1;
            endcase
        end else begin
            case (eff_cmd_c)
                L_NOT_A, L_SHR1_A, L_SHL1_A: need_b_c = 1'b0;
                L_NOT_B, L_SHR1_B, L_SHL1_B: need_a_c = 1'b0;
                L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_ROL, L_ROR: ;
                default: illegal_c = 1'b1;
            endcase
        end
        done_c = illegal_c | ((have_a_c | ~need_a_c) & (have_b_c | ~need_b_c));
    end

    // Rotators: index arithmetic wraps modulo WIDTH in SHAMT_W bits.
    always_comb begin
        rot_amt_c = eff_b_c[SHAMT_W-1:0];
        rot_bad_c = |eff_b_c[WIDTH-1:SHAMT_W+1];
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rol_c[i] = eff_a_c[SHAMT_W'(i) - rot_amt_c];
            ror_c[i] = eff_a_c[SHAMT_W'(i) + rot_amt_c];
        end
    end

    // Result and flags for the effective command; undefined flags stay 0.
    always_comb begin
        xa_c      = {1'b0, eff_a_c};
        xb_c      = {1'b0, eff_b_c};
        xc_c      = (WIDTH+1)'(eff_cin_c);
        r_res_c   = '0;
        r_cout_c  = 1'b0;
        r_oflow_c = 1'b0;
        r_g_c     = 1'b0;
        r_e_c     = 1'b0;
        r_l_c     = 1'b0;
        r_err_c   = illegal_c;
        if (!illegal_c) begin
            if (eff_mode_c) begin
                case (eff_cmd_c)
                    A_ADD:     begin r_res_c = xa_c + xb_c;        r_cout_c = r_res_c[WIDTH]; end
                    A_SUB:     begin r_res_c = xa_c - xb_c;        r_oflow_c = (xa_c < xb_c); end
                    A_ADD_CIN: begin r_res_c = xa_c + xb_c + xc_c; r_cout_c = r_res_c[WIDTH]; end
                    A_SUB_CIN: begin r_res_c = xa_c - xb_c - xc_c; r_oflow_c = (xa_c < (xb_c + xc_c)); end
                    A_INC_A:   r_res_c = xa_c + (WIDTH+1)'(1);
                    A_DEC_A:   begin r_res_c = xa_c - (WIDTH+1)'(1); r_oflow_c = (eff_a_c == '0); end
                    A_INC_B:   r_res_c = xb_c + (WIDTH+1)'(1);
                    A_DEC_B:   begin r_res_c = xb_c - (WIDTH+1)'(1); r_oflow_c = (eff_b_c == '0); end
                    A_CMP: begin
                        r_g_c = (eff_a_c > eff_b_c);
                        r_e_c = (eff_a_c == eff_b_c);
                        r_l_c = (eff_a_c < eff_b_c);
                    end
                    default: ;
                endcase
            end else begin
                case (eff_cmd_c)
                    L_AND:    r_res_c = {1'b0, eff_a_c & eff_b_c};
                    L_NAND:   r_res_c = {1'b0, ~(eff_a_c & eff_b_c)};
                    L_OR:     r_res_c = {1'b0, eff_a_c | eff_b_c};
                    L_NOR:    r_res_c = {1'b0, ~(eff_a_c | eff_b_c)};
                    L_XOR:    r_res_c = {1'b0, eff_a_c ^ eff_b_c};
                    L_XNOR:   r_res_c = {1'b0, ~(eff_a_c ^ eff_b_c)};
                    L_NOT_A:  r_res_c = {1'b0, ~eff_a_c};
                    L_NOT_B:  r_res_c = {1'b0, ~eff_b_c};
                    L_SHR1_A: r_res_c = {1'b0, eff_a_c >> 1};
                    L_SHL1_A: r_res_c = {1'b0, eff_a_c << 1};
                    L_SHR1_B: r_res_c = {1'b0, eff_b_c >> 1};
                    L_SHL1_B: r_res_c = {1'b0, eff_b_c << 1};
                    L_ROL, L_ROR: begin
                        if (rot_bad_c) r_err_c = 1'b1;
                        else           r_res_c = {1'b0, (eff_cmd_c == L_ROL) ? rol_c : ror_c};
                    end
                    default: ;
                endcase
            end
        end
    end

    // Operand collection FSM and registered result bundle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            cmd_q     <= '0;
            mode_q    <= 1'b0;
            cin_q     <= 1'b0;
            bus.res   <= '0;
            bus.cout  <= 1'b0;
            bus.oflow <= 1'b0;
            bus.G     <= 1'b0;
            bus.E     <= 1'b0;
            bus.L     <= 1'b0;
            bus.err   <= 1'b0;
        end else if (bus.ce) begin
            if (bus.inp_valid[0]) a_q <= bus.op_a;
            if (bus.inp_valid[1]) b_q <= bus.op_b;
            case (state_q)
                ST_IDLE: begin
                    if (bus.inp_valid != 2'b00) begin
                        if (!done_c) begin
                            a_vld_q <= bus.inp_valid[0];
                            b_vld_q <= bus.inp_valid[1];
                            cmd_q   <= bus.cmd;
                            mode_q  <= bus.mode;
                            cin_q   <= bus.cin;
                            cnt_q   <= '0;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.inp_valid[0]) a_vld_q <= 1'b1;
                    if (bus.inp_valid[1]) b_vld_q <= 1'b1;
                    if (done_c || cnt_q == CNT_W'(TIMEOUT - 1)) state_q <= ST_IDLE;
                    else                                         cnt_q   <= cnt_q + CNT_W'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
            // Issue a completed result, or an error when the last wait cycle expires.
            if ((state_q == ST_IDLE && bus.inp_valid != 2'b00 && done_c) ||
                (state_q == ST_WAIT && done_c)) begin
                bus.res   <= r_res_c;
                bus.cout  <= r_cout_c;
                bus.oflow <= r_oflow_c;
                bus.G     <= r_g_c;
                bus.E     <= r_e_c;
                bus.L     <= r_l_c;
                bus.err   <= r_err_c;
            end else if (state_q == ST_WAIT && cnt_q == CNT_W'(TIMEOUT - 1)) begin
                bus.res   <= '0;
                bus.cout  <= 1'b0;
                bus.oflow <= 1'b0;
                bus.G     <= 1'b0;
                bus.E     <= 1'b0;
                bus.L     <= 1'b0;
                bus.err   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed scenarios plus randomized
// single-cycle and split-operand traffic against an arithmetic reference model.
module tb_alu_core;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned CMD_WIDTH = 4;
    localparam int unsigned TIMEOUT   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH)) bus ();

    alu_core #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [14:0] last_exp = '0;   // {res[8:0], cout, oflow, G, E, L, err}
    logic [14:0] got;
    logic [14:0] exp;

    // Reference: result bundle from plain integer arithmetic.
    function automatic logic [14:0] model(input logic m, input logic [3:0] c,
                                          input logic [7:0] a, input logic [7:0] b, input logic ci);
        int ai, bi, cc, r, k;
        logic co, of, g, e, l, er;
        ai = int'(a); bi = int'(b); cc = int'(ci);
        r = 0; co = 0; of = 0; g = 0; e = 0; l = 0; er = 0;
        k = bi % 8;
        if (m) begin
            case (c)
                4'd0: begin r = ai + bi;      co = (r > 255); end
                4'd1: begin r = ai - bi;      of = (ai < bi); end
                4'd2: begin r = ai + bi + cc; co = (r > 255); end
                4'd3: begin r = ai - bi - cc; of = (ai < bi + cc); end
                4'd4: r = ai + 1;
                4'd5: begin r = ai - 1; of = (ai == 0); end
                4'd6: r = bi + 1;
                4'd7: begin r = bi - 1; of = (bi == 0); end
                4'd8: begin g = (ai > bi); e = (ai == bi); l = (ai < bi); end
                default: er = 1;
            endcase
        end else begin
            case (c)
                4'd0:  r = ai & bi;
                4'd1:  r = 255 - (ai & bi);
                4'd2:  r = ai | bi;
                4'd3:  r = 255 - (ai | bi);
                4'd4:  r = ai ^ bi;
                4'd5:  r = 255 - (ai ^ bi);
                4'd6:  r = 255 - ai;
                4'd7:  r = 255 - bi;
                4'd8:  r = ai / 2;
                4'd9:  r = (ai * 2) % 256;
                4'd10: r = bi / 2;
                4'd11: r = (bi * 2) % 256;
                4'd12: if (bi >= 16) er = 1; else r = ((ai << k) | (ai >> (8 - k))) % 256;
                4'd13: if (bi >= 16) er = 1; else r = ((ai >> k) | (ai << (8 - k))) % 256;
                default: er = 1;
            endcase
        end
        return {9'(r & 511), co, of, g, e, l, er};
    endfunction

    // Which operands (bit0 = A, bit1 = B) a legal command needs.
    function automatic logic [1:0] need(input logic m, input logic [3:0] c);
        if (m) begin
            if (c == 4'd4 || c == 4'd5) return 2'b01;
            if (c == 4'd6 || c == 4'd7) return 2'b10;
            return 2'b11;
        end
        if (c == 4'd6 || c == 4'd8 || c == 4'd9) return 2'b01;
        if (c == 4'd7 || c == 4'd10 || c == 4'd11) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [14:0] obs();
        return {bus.res, bus.cout, bus.oflow, bus.G, bus.E, bus.L, bus.err};
    endfunction

    task automatic drive(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic ci, input logic [1:0] v);
        bus.mode = m; bus.cmd = c; bus.op_a = a; bus.op_b = b;
        bus.cin = ci; bus.inp_valid = v; bus.ce = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
        step(); step();
        got = obs(); checks++;
        if (got !== 15'h0) begin errors++; $display("FAIL reset_state: got %h want %h", got, 15'h0); end
        rst = 1'b1;
        drive(1'b1, 4'd0, 8'd1, 8'd2, 1'b0, 2'b11);
        step();
        exp = {9'h003, 6'b0}; got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_pre_add: got %h want %h", got, exp); end
        drive(1'b1, 4'd0, 8'd5, 8'd0, 1'b0, 2'b01);
        step();
        got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_wait_hold: got %h want %h", got, exp); end
        #2 rst = 1'b0;
        #1;
        got = obs(); checks++;
        if (got !== 15'h0) begin errors++; $display("FAIL reset_async_in_wait: got %h want %h", got, 15'h0); end
        #1 rst = 1'b1;
        drive(1'b1, 4'd0, 8'd3, 8'd4, 1'b0, 2'b11);
        step();
        exp = {9'h007, 6'b0}; got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_post_add: got %h want %h", got, exp); end
        last_exp = exp;
    endtask

    task automatic test_add_boundary();
        drive(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11);
        step();
        exp = {9'h100, 1'b1, 5'b0}; got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL add_boundary: got %h want %h", got, exp); end
        last_exp = exp;
    endtask

    task automatic test_split();
        drive(1'b1, 4'd1, 8'h10, 8'hAA, 1'b0, 2'b01);
        step();
        got = obs(); checks++;
        if (got !== last_exp) begin errors++; $display("FAIL split_hold0: got %h want %h", got, last_exp); end
        for (int i = 1; i <= 2; i++) begin
            drive(1'b0, 4'd2, 8'h55, 8'h66, 1'b1, 2'b00);
            step();
            got = obs(); checks++;
            if (got !== last_exp) begin errors++; $display("FAIL split_hold%0d: got %h want %h", i, got, last_exp); end
        end
        drive(1'b0, 4'd2, 8'h77, 8'h20, 1'b1, 2'b10);
        step();
        exp = {9'h1F0, 1'b0, 1'b1, 4'b0}; got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL split_result: got %h want %h", got, exp); end
        last_exp = exp;
    endtask

    task automatic test_timeout();
        logic [14:0] err_v;
        err_v = {9'h0, 5'b0, 1'b1};
        // Plain timeout
        drive(1'b1, 4'd0, 8'h11, 8'h00, 1'b0, 2'b01);
        step();
        for (int i = 1; i <= 15; i++) begin drive(1'b1, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00); step(); end
        got = obs(); checks++;
        if (got !== last_exp) begin errors++; $display("FAIL timeout_hold15: got %h want %h", got, last_exp); end
        step();
        got = obs(); checks++;
        if (got !== err_v) begin errors++; $display("FAIL timeout_err: got %h want %h", got, err_v); end
        last_exp = err_v;
        // Operand arriving in the last wait cycle
        drive(1'b1, 4'd0, 8'h11, 8'h00, 1'b0, 2'b01);
        step();
        for (int i = 1; i <= 15; i++) begin drive(1'b1, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00); step(); end
        got = obs(); checks++;
        if (got !== last_exp) begin errors++; $display("FAIL timeout_late_hold: got %h want %h", got, last_exp); end
        drive(1'b1, 4'd0, 8'h00, 8'h22, 1'b0, 2'b10);
        step();
        exp = {9'h033, 6'b0}; got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL timeout_late_b: got %h want %h", got, exp); end
        last_exp = exp;
        // Clock-enable gaps defer the timeout
        drive(1'b1, 4'd0, 8'h11, 8'h00, 1'b0, 2'b01);
        step();
        for (int i = 1; i <= 5; i++) begin drive(1'b1, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00); step(); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b11);
            bus.ce = 1'b0;
            step();
        end
        got = obs(); checks++;
        if (got !== last_exp) begin errors++; $display("FAIL timeout_ce_hold: got %h want %h", got, last_exp); end
        for (int i = 6; i <= 15; i++) begin drive(1'b1, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00); step(); end
        got = obs(); checks++;
        if (got !== last_exp) begin errors++; $display("FAIL timeout_ce_deferred: got %h want %h", got, last_exp); end
        step();
        got = obs(); checks++;
        if (got !== err_v) begin errors++; $display("FAIL timeout_ce_err: got %h want %h", got, err_v); end
        last_exp = err_v;
        // ce=0 in idle ignores a complete operation
        drive(1'b1, 4'd0, 8'h02, 8'h03, 1'b0, 2'b11);
        bus.ce = 1'b0;
        step();
        got = obs(); checks++;
        if (got !== last_exp) begin errors++; $display("FAIL ce_idle_hold: got %h want %h", got, last_exp); end
    endtask

    task automatic test_cmp_illegal();
        drive(1'b1, 4'd8, 8'd5, 8'd9, 1'b0, 2'b11);
        step();
        exp = {9'h0, 5'b00001, 1'b0}; got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL cmp_lt: got %h want %h", got, exp); end
        drive(1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
        step();
        drive(1'b1, 4'd9, 8'd1, 8'd1, 1'b0, 2'b11);
        step();
        exp = {9'h0, 5'b0, 1'b1}; got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL illegal_arith: got %h want %h", got, exp); end
        drive(1'b0, 4'd3, 8'hF0, 8'h01, 1'b0, 2'b11);
        step();
        drive(1'b0, 4'd14, 8'h01, 8'h00, 1'b0, 2'b01);
        step();
        got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL illegal_logic: got %h want %h", got, exp); end
        last_exp = exp;
    endtask

    task automatic test_rotate();
        drive(1'b0, 4'd12, 8'h81, 8'h01, 1'b0, 2'b11);
        step();
        exp = {9'h003, 6'b0}; got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rol: got %h want %h", got, exp); end
        drive(1'b0, 4'd12, 8'h81, 8'h11, 1'b0, 2'b11);
        step();
        exp = {9'h0, 5'b0, 1'b1}; got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rol_bad_amt: got %h want %h", got, exp); end
        drive(1'b0, 4'd13, 8'h01, 8'h01, 1'b0, 2'b11);
        step();
        exp = {9'h080, 6'b0}; got = obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ror: got %h want %h", got, exp); end
        last_exp = exp;
    endtask

    task automatic test_random_single();
        logic m, ci;
        logic [3:0] c;
        logic [7:0] a, b;
        for (int n = 0; n < 120; n++) begin
            m  = 1'($urandom_range(0, 1));
            c  = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
            ci = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 5) == 0) begin
                drive(~m, c, b, a, ~ci, 2'b00);
                step();
                got = obs(); checks++;
                if (got !== last_exp) begin errors++; $display("FAIL rand_idle_hold n=%0d: got %h want %h", n, got, last_exp); end
            end
            drive(m, c, a, b, ci, 2'b11);
            step();
            exp = model(m, c, a, b, ci); got = obs(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_single mode=%0d cmd=%0d a=%h b=%h cin=%0d: got %h want %h", m, c, a, b, ci, got, exp);
            end
            last_exp = exp;
        end
    endtask

    task automatic test_random_split();
        logic m, ci, resend;
        logic [3:0] c;
        logic [7:0] a, b, na, nb;
        logic [1:0] nd, v, vv, miss;
        int k;
        for (int n = 0; n < 50; n++) begin
            m  = 1'($urandom_range(0, 1));
            c  = m ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 13));
            a  = 8'($urandom);
            b  = 8'($urandom_range(0, 20));
            ci = 1'($urandom_range(0, 1));
            nd = need(m, c);
            v  = 2'($urandom_range(1, 3));
            drive(m, c, a, b, ci, v);
            step();
            if ((v & nd) == nd) begin
                exp = model(m, c, a, b, ci); got = obs(); checks++;
                if (got !== exp) begin errors++; $display("FAIL rand_split_direct n=%0d: got %h want %h", n, got, exp); end
                last_exp = exp;
            end else begin
                got = obs(); checks++;
                if (got !== last_exp) begin errors++; $display("FAIL rand_split_entry_hold n=%0d: got %h want %h", n, got, last_exp); end
                k = $urandom_range(0, 6);
                for (int j = 0; j < k; j++) begin
                    na = 8'($urandom); nb = 8'($urandom_range(0, 20));
                    resend = 1'($urandom_range(0, 1));
                    vv = resend ? v : 2'b00;
                    if (vv[0]) a = na;
                    if (vv[1]) b = nb;
                    drive(1'($urandom), 4'($urandom), na, nb, 1'($urandom), vv);
                    step();
                    got = obs(); checks++;
                    if (got !== last_exp) begin errors++; $display("FAIL rand_split_wait_hold n=%0d j=%0d: got %h want %h", n, j, got, last_exp); end
                end
                miss = nd & ~v;
                na = 8'($urandom); nb = 8'($urandom_range(0, 20));
                if (miss[0]) a = na;
                if (miss[1]) b = nb;
                drive(1'($urandom), 4'($urandom), na, nb, 1'($urandom), miss);
                step();
                exp = model(m, c, a, b, ci); got = obs(); checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rand_split_done n=%0d mode=%0d cmd=%0d a=%h b=%h: got %h want %h", n, m, c, a, b, got, exp);
                end
                last_exp = exp;
            end
        end
    endtask

    initial begin
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
        test_reset();
        test_add_boundary();
        test_split();
        test_timeout();
        test_cmp_illegal();
        test_rotate();
        test_random_single();
        test_random_split();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
